// File: rtl/conv_mac_pipe_if.sv
// conv_mac_pipe_if: valid/ready window-beat input and result output bundle of the MAC engine
interface conv_mac_pipe_if #(
  parameter int DATA_W   = 6,
  parameter int KERNEL_W = 6,
  parameter int TAPS     = 9,
  parameter int OUT_W    = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*DATA_W-1:0]   in_data;
  logic [TAPS*KERNEL_W-1:0] kernel;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;
  modport master (
    output in_valid, in_data, kernel, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_data, kernel, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined KxK multiply, adder-tree reduce and channel accumulate with saturation
module conv_mac_pipe #(
  parameter int DATA_W   = 6,
  parameter int KERNEL_W = 6,
  parameter int TAPS     = 9,
  parameter int ACC_CH   = 1,
  parameter int OUT_W    = 18,
  parameter int SIGNED   = 0
) (
  input logic            clk,
  input logic            rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int PROD_W = DATA_W + KERNEL_W;
  localparam int LG     = $clog2(TAPS);
  localparam int NP     = 1 << LG;
  localparam int TREE_W = PROD_W + LG;
  localparam int ACC_W  = TREE_W + $clog2(ACC_CH);
  localparam int CNT_W  = ACC_CH > 1 ? $clog2(ACC_CH) : 1;
  localparam bit SX     = SIGNED != 0;
  logic              adv, v1, v2, last, out_valid, out_sat, sat_flag;
  logic [PROD_W-1:0] prod_d [TAPS];
  logic [PROD_W-1:0] prod_q [TAPS];
  logic [TREE_W-1:0] tree_sum, tree_q;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]  ch_cnt;
  logic [OUT_W-1:0]  out_data, sat_val;
  assign adv           = !out_valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;
  // Low PROD_W bits of the product depend only on the low PROD_W operand bits, so PROD_W-wide math is exact
  for (genvar i = 0; i < TAPS; i++) begin : g_mul
    logic [DATA_W-1:0]   a;
    logic [KERNEL_W-1:0] b;
    assign a         = bus.in_data[i*DATA_W +: DATA_W];
    assign b         = bus.kernel[i*KERNEL_W +: KERNEL_W];
    assign prod_d[i] = SX ? PROD_W'($signed(a)) * PROD_W'($signed(b)) : PROD_W'(a) * PROD_W'(b);
  end
  // Balanced tree padded to a power of two; level l holds NP>>l partial sums
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [TREE_W-1:0] s [NP >> l];
    for (genvar i = 0; i < (NP >> l); i++) begin : g_n
      if (l > 0) begin : g_add
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end else if (i < TAPS) begin : g_leaf
        assign s[i] = SX ? TREE_W'($signed(prod_q[i])) : TREE_W'(prod_q[i]);
      end else begin : g_pad
        assign s[i] = '0;
      end
    end
  end
  assign tree_sum = g_lvl[LG].s[0];
  assign last     = ch_cnt == CNT_W'(ACC_CH - 1);
  assign acc_next = (ch_cnt == '0 ? '0 : acc) + (SX ? ACC_W'($signed(tree_q)) : ACC_W'(tree_q));
  if (ACC_W <= OUT_W) begin : g_nosat
    assign sat_val  = SX ? OUT_W'($signed(acc_next)) : OUT_W'(acc_next);
    assign sat_flag = 1'b0;
  end else begin : g_sat
    logic [ACC_W-OUT_W:0] hi;
    assign hi       = acc_next[ACC_W-1:OUT_W-1];
    assign sat_flag = SX ? !(&hi || ~|hi) : |hi[ACC_W-OUT_W:1];
    assign sat_val  = !sat_flag ? acc_next[OUT_W-1:0] :
                      SX ? {acc_next[ACC_W-1], {(OUT_W-1){~acc_next[ACC_W-1]}}} : '1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      ch_cnt    <= '0;
      acc       <= '0;
    end else if (adv) begin
      v1        <= bus.in_valid;
      v2        <= v1;
      out_valid <= v2 && last;
      if (v2 && last) begin
        out_data <= sat_val;
        out_sat  <= sat_flag;
        ch_cnt   <= '0;
      end else if (v2) begin
        acc    <= acc_next;
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (adv) begin
      for (int i = 0; i < TAPS; i++)
        if (bus.in_valid) prod_q[i] <= prod_d[i];
      if (v1) tree_q <= tree_sum;
    end
endmodule
